// File: rtl/sdp_y_pack_pkg.sv
// Shared definitions for the SDP Y-path gather/pack stage.
package sdp_y_pack_pkg;

    localparam int unsigned DEF_IW    = 128;
    localparam int unsigned DEF_RATIO = 4;
    // Upper bound on RATIO supported by the mask helper.
    localparam int unsigned MAX_RATIO = 64;

    // Segment counter for the default build.
    typedef logic [$clog2(DEF_RATIO)-1:0] seg_cnt_t;

    // Thermometer mask: bits 0..cnt set, everything above clear.
    function automatic logic [MAX_RATIO-1:0] therm_mask(input int unsigned cnt);
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_RATIO; i++) begin
            m[i] = (i <= cnt);
        end
        return m;
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_y_pack_ctrl.sv
// Control half of the Y-path packer: group counter, ratio latch,
// output valid/mask/last register and the accepted-word counter.
module nv_nvdla_sdp_y_pack_ctrl
    import sdp_y_pack_pkg::*;
#(
    parameter int unsigned RATIO = DEF_RATIO,
    parameter int unsigned CW    = $clog2(RATIO)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic [CW-1:0]    cfg_ratio_m1,
    input  logic             inp_pvld,
    input  logic             inp_last,
    input  logic             out_prdy,
    output logic             inp_prdy,
    output logic             inp_acc,
    output logic [CW-1:0]    seg_idx,
    output logic             out_pvld,
    output logic [RATIO-1:0] out_mask,
    output logic             out_last,
    output logic [31:0]      out_word_cnt
);

    logic [CW-1:0] pack_cnt;
    logic [CW-1:0] lat_m1;
    logic [CW-1:0] cur_m1;
    logic          is_last;
    logic          out_acc;

    // The held word blocks new input only when downstream is not taking it.
    assign inp_prdy = !out_pvld || out_prdy;
    assign inp_acc  = inp_pvld && inp_prdy;
    assign out_acc  = out_pvld && out_prdy;

    // The first beat of a group sees the live config; later beats see the latched copy.
    assign cur_m1  = (pack_cnt == '0) ? cfg_ratio_m1 : lat_m1;
    assign is_last = (pack_cnt == cur_m1) || inp_last;
    assign seg_idx = pack_cnt;

    // Group progress, output word flags and word counter.
    always_ff @(posedge nvdla_core_clk) begin
        // NOTE: state registers use non-blocking assignments so every read in
        // this block sees the pre-edge value, matching the hardware registers.
        if (nvdla_core_rst) begin
            pack_cnt     <= '0;
            lat_m1       <= '0;
            out_pvld     <= 1'b0;
            out_mask     <= '0;
            out_last     <= 1'b0;
            out_word_cnt <= '0;
        end else begin
            if (inp_acc) begin
                if (pack_cnt == '0) begin
                    lat_m1 <= cfg_ratio_m1;
                end
                pack_cnt <= is_last ? '0 : pack_cnt + 1'b1;
            end
            if (inp_prdy) begin
                out_pvld <= inp_acc && is_last;
            end
            if (inp_acc && is_last) begin
                out_mask <= RATIO'(therm_mask(32'(pack_cnt)));
                out_last <= inp_last;
            end
            if (out_acc) begin
                out_word_cnt <= out_word_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_core_y_dpunpack_param.sv
// Parametrised gather/pack stage: RATIO narrow beats -> one wide masked word.
module nv_nvdla_sdp_core_y_dpunpack_param
    import sdp_y_pack_pkg::*;
#(
    parameter int unsigned IW    = DEF_IW,
    parameter int unsigned RATIO = DEF_RATIO,
    parameter int unsigned CW    = $clog2(RATIO)
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rst,
    input  logic [CW-1:0]       cfg_ratio_m1,
    input  logic                inp_pvld,
    output logic                inp_prdy,
    input  logic [IW-1:0]       inp_data,
    input  logic                inp_last,
    output logic                out_pvld,
    input  logic                out_prdy,
    output logic [IW*RATIO-1:0] out_data,
    output logic [RATIO-1:0]    out_mask,
    output logic                out_last,
    output logic [31:0]         out_word_cnt
);

    logic          inp_acc;
    logic [CW-1:0] seg_idx;
    logic [IW-1:0] seg [RATIO];

    nv_nvdla_sdp_y_pack_ctrl #(
        .RATIO (RATIO),
        .CW    (CW)
    ) u_ctrl (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .cfg_ratio_m1   (cfg_ratio_m1),
        .inp_pvld       (inp_pvld),
        .inp_last       (inp_last),
        .out_prdy       (out_prdy),
        .inp_prdy       (inp_prdy),
        .inp_acc        (inp_acc),
        .seg_idx        (seg_idx),
        .out_pvld       (out_pvld),
        .out_mask       (out_mask),
        .out_last       (out_last),
        .out_word_cnt   (out_word_cnt)
    );

    // Capture each accepted beat into the segment slot the counter points at.
    always_ff @(posedge nvdla_core_clk) begin
        // NOTE: the segment array has no reset on purpose; every segment read
        // downstream is masked, so reset would only add enable/reset fan-out.
        if (inp_acc) begin
            seg[seg_idx] <= inp_data;
        end
    end

    // Unfilled segments read as zero so stale data from earlier groups never leaks.
    for (genvar i = 0; i < RATIO; i++) begin : g_seg
        assign out_data[i*IW +: IW] = seg[i] & {IW{out_mask[i]}};
    end

endmodule

// File: tb/tb_nv_nvdla_sdp_core_y_dpunpack_param.sv
// Self-checking bench: directed scenarios plus random traffic, all outputs
// compared every cycle against a beat-list reference model.
module tb_nv_nvdla_sdp_core_y_dpunpack_param;
    import sdp_y_pack_pkg::*;

    localparam int unsigned IW    = 128;
    localparam int unsigned RATIO = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned OW    = IW * RATIO;

    logic             clk = 1'b0;
    logic             rst;
    seg_cnt_t         cfg_ratio_m1;
    logic             inp_pvld;
    logic             inp_prdy;
    logic [IW-1:0]    inp_data;
    logic             inp_last;
    logic             out_pvld;
    logic             out_prdy;
    logic [OW-1:0]    out_data;
    logic [RATIO-1:0] out_mask;
    logic             out_last;
    logic [31:0]      out_word_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a list of beats for the open group, plus one held word.
    logic [IW-1:0] grp_beats [RATIO];
    int            grp_n     = 0;
    int            grp_size  = 0;
    logic          m_pvld    = 1'b0;
    logic [OW-1:0] m_data    = '0;
    logic [RATIO-1:0] m_mask = '0;
    logic          m_last    = 1'b0;
    logic [31:0]   m_cnt     = '0;

    always #5 clk = ~clk;

    nv_nvdla_sdp_core_y_dpunpack_param #(
        .IW    (IW),
        .RATIO (RATIO),
        .CW    (CW)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cfg_ratio_m1   (cfg_ratio_m1),
        .inp_pvld       (inp_pvld),
        .inp_prdy       (inp_prdy),
        .inp_data       (inp_data),
        .inp_last       (inp_last),
        .out_pvld       (out_pvld),
        .out_prdy       (out_prdy),
        .out_data       (out_data),
        .out_mask       (out_mask),
        .out_last       (out_last),
        .out_word_cnt   (out_word_cnt)
    );

    task automatic check(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] word4(input logic [IW-1:0] s0, input logic [IW-1:0] s1,
                                            input logic [IW-1:0] s2, input logic [IW-1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    // Compare DUT against the model, then advance the model by one clock.
    task automatic model_step();
        logic exp_prdy;
        logic acc;
        exp_prdy = !m_pvld || out_prdy;
        check("inp_prdy", OW'(inp_prdy), OW'(exp_prdy));
        check("out_pvld", OW'(out_pvld), OW'(m_pvld));
        check("word_cnt", OW'(out_word_cnt), OW'(m_cnt));
        if (m_pvld) begin
            check("out_data", out_data, m_data);
            check("out_mask", OW'(out_mask), OW'(m_mask));
            check("out_last", OW'(out_last), OW'(m_last));
        end
        if (rst) begin
            m_pvld = 1'b0;
            m_cnt  = '0;
            grp_n  = 0;
            return;
        end
        acc = inp_pvld && exp_prdy;
        if (m_pvld && out_prdy) begin
            m_pvld = 1'b0;
            m_cnt  = m_cnt + 1;
        end
        if (acc) begin
            if (grp_n == 0) grp_size = int'(cfg_ratio_m1) + 1;
            grp_beats[grp_n] = inp_data;
            grp_n++;
            if (grp_n == grp_size || inp_last) begin
                m_data = '0;
                for (int i = 0; i < grp_n; i++) m_data[i*IW +: IW] = grp_beats[i];
                m_mask = RATIO'((1 << grp_n) - 1);
                m_last = inp_last;
                m_pvld = 1'b1;
                grp_n  = 0;
            end
        end
    endtask

    // One clock: drive inputs, check at the falling edge, return just after the rising edge.
    task automatic cycle(input logic pv, input logic [IW-1:0] d, input logic lst,
                         input logic pr, input logic [CW-1:0] cfg, input logic r);
        inp_pvld = pv; inp_data = d; inp_last = lst;
        out_prdy = pr; cfg_ratio_m1 = cfg; rst = r;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [OW-1:0] held;
        rst = 1'b1; inp_pvld = 1'b0; inp_data = '0; inp_last = 1'b0;
        out_prdy = 1'b0; cfg_ratio_m1 = '0;
        @(posedge clk);
        #1;
        check("rst_pvld", OW'(out_pvld), '0);
        check("rst_mask", OW'(out_mask), '0);
        check("rst_last", OW'(out_last), '0);
        check("rst_cnt",  OW'(out_word_cnt), '0);

        // Full group of four.
        cycle(1, IW'(32'hA), 0, 1, 3, 0);
        cycle(1, IW'(32'hB), 0, 1, 3, 0);
        cycle(1, IW'(32'hC), 0, 1, 3, 0);
        check("full_pvld_early", OW'(out_pvld), '0);
        cycle(1, IW'(32'hD), 0, 1, 3, 0);
        check("full_pvld", OW'(out_pvld), OW'(1));
        check("full_mask", OW'(out_mask), OW'(4'b1111));
        check("full_last", OW'(out_last), '0);
        check("full_data", out_data, word4(IW'(32'hA), IW'(32'hB), IW'(32'hC), IW'(32'hD)));
        cycle(0, '0, 0, 1, 3, 0);
        check("full_cnt", OW'(out_word_cnt), OW'(1));

        // Early close by inp_last, then the next group starts at segment 0.
        cycle(1, IW'(32'h11), 0, 1, 3, 0);
        cycle(1, IW'(32'h22), 1, 1, 3, 0);
        check("early_mask", OW'(out_mask), OW'(4'b0011));
        check("early_last", OW'(out_last), OW'(1));
        check("early_data", out_data, word4(IW'(32'h11), IW'(32'h22), '0, '0));
        cycle(1, IW'(32'h33), 0, 1, 0, 0);
        check("early_next", out_data, word4(IW'(32'h33), '0, '0, '0));
        cycle(0, '0, 0, 1, 0, 0);

        // Backpressure: held word stays put, input stalls, release accepts a new beat.
        cycle(1, IW'(32'h44), 0, 0, 1, 0);
        cycle(1, IW'(32'h55), 0, 0, 1, 0);
        held = word4(IW'(32'h44), IW'(32'h55), '0, '0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, IW'(32'h66), 0, 0, 0, 0);
            check("bp_prdy", OW'(inp_prdy), '0);
            check("bp_data", out_data, held);
            check("bp_mask", OW'(out_mask), OW'(4'b0011));
        end
        cycle(1, IW'(32'h66), 0, 1, 0, 0);
        check("bp_new", out_data, word4(IW'(32'h66), '0, '0, '0));
        check("bp_new_mask", OW'(out_mask), OW'(4'b0001));

        // Pass-through: one word per cycle.
        for (int i = 0; i < 8; i++) begin
            cycle(1, IW'(32'h100 + i), 0, 1, 0, 0);
            check("pt_pvld", OW'(out_pvld), OW'(1));
            check("pt_data", out_data, word4(IW'(32'h100 + i), '0, '0, '0));
        end
        cycle(0, '0, 0, 1, 0, 0);

        // Mid-group config change is ignored until the next group.
        cycle(1, IW'(32'h71), 0, 1, 1, 0);
        cycle(1, IW'(32'h72), 0, 1, 3, 0);
        check("cfg_mask", OW'(out_mask), OW'(4'b0011));
        for (int i = 0; i < 4; i++) cycle(1, IW'(32'h80 + i), 0, 1, 3, 0);
        check("cfg_next_mask", OW'(out_mask), OW'(4'b1111));
        cycle(0, '0, 0, 1, 3, 0);

        // Reset mid-group drops the partial group.
        cycle(1, IW'(32'h91), 0, 1, 3, 0);
        cycle(1, IW'(32'h92), 0, 1, 3, 0);
        cycle(0, '0, 0, 1, 3, 1);
        check("rmid_pvld", OW'(out_pvld), '0);
        check("rmid_cnt", OW'(out_word_cnt), '0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, IW'(32'hA0 + i), 0, 1, 3, 0);
            check("rmid_wait", OW'(out_pvld), '0);
        end
        cycle(1, IW'(32'hA3), 0, 1, 3, 0);
        check("rmid_mask", OW'(out_mask), OW'(4'b1111));
        check("rmid_data", out_data, word4(IW'(32'hA0), IW'(32'hA1), IW'(32'hA2), IW'(32'hA3)));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) != 0,
                  CW'($urandom_range(0, 3)),
                  $urandom_range(0, 299) == 0);
        end
        cycle(0, '0, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_sdp_core_y_dpunpack_param.md
Name: nv_nvdla_sdp_core_y_dpunpack_param

Overview:
- Parametrised gather/pack stage for the SDP Y datapath.
- Collects up to RATIO narrow beats of IW bits and emits them as one wide beat of IW*RATIO bits over a valid/ready handshake.
- Successor to the fixed 128->512 packer, with three additions:
  - group size is runtime-programmable;
  - a group can be closed early by an input last flag; the output then carries a segment mask and a last flag;
  - a counter of emitted words.

Parameters:
- IW, 128, width of one input beat in bits.
- RATIO, 4, maximum beats per output word; power of 2, >= 2.
- CW, $clog2(RATIO), width of the segment counter and of the ratio config field.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rst  in  1  synchronous reset, active-high.
- cfg_ratio_m1  in  CW  beats per group minus 1 (0 = pass-through).
- inp_pvld  in  1  input beat valid.
- inp_prdy  out  1  input beat ready.
- inp_data  in  IW  input beat payload.
- inp_last  in  1  closes the current group after this beat.
- out_pvld  out  1  packed word valid.
- out_prdy  in  1  packed word ready.
- out_data  out  IW*RATIO  packed word; segment i is bits [i*IW +: IW].
- out_mask  out  RATIO  bit i = segment i carries valid data.
- out_last  out  1  group was closed by inp_last.
- out_word_cnt  out  32  number of words accepted downstream; wraps.

Behaviour:
- Reset (nvdla_core_rst=1 at a clock edge):
  - out_pvld=0, out_mask=0, out_last=0, out_word_cnt=0;
  - pack_cnt=0, latched ratio=0;
  - segment data registers are not reset.
  - Reset mid-group discards the partial group; no output is produced for it.
- Handshake:
  - inp_prdy = !out_pvld | out_prdy (combinational).
  - inp_acc = inp_pvld & inp_prdy; out_acc = out_pvld & out_prdy.
  - out_pvld, out_data, out_mask and out_last are stable while out_pvld=1 and out_prdy=0.
- Ratio latch:
  - On an inp_acc with pack_cnt==0, the latched ratio (lat_m1) loads cfg_ratio_m1.
  - Beats 1..N of the group use lat_m1; cfg changes mid-group are ignored.
- Counter:
  - is_last = (pack_cnt == cur_m1) | inp_last, where cur_m1 = cfg_ratio_m1 when pack_cnt==0, else lat_m1.
  - On inp_acc: pack_cnt <= is_last ? 0 : pack_cnt+1.
- Segment capture: on inp_acc, seg[pack_cnt] <= inp_data.
- Output register:
  - Whenever inp_prdy=1: out_pvld <= inp_acc & is_last.
  - When inp_acc & is_last:
    - out_mask <= (2 << pack_cnt) - 1, i.e. bits 0..pack_cnt set;
    - out_last <= inp_last.
- out_data gating: each segment is ANDed with its out_mask bit, so unfilled segments read zero (no stale data).
- Latency: the word appears the cycle after the closing beat is accepted.
- Throughput: one input beat per cycle with out_prdy held high, including back-to-back single-beat groups (cfg_ratio_m1=0).
- Simultaneous events: out_acc and inp_acc in the same cycle is legal. The held word is consumed, seg[pack_cnt] is overwritten, and out_pvld follows the new is_last.
- inp_last on the beat where pack_cnt == lat_m1: full mask, out_last=1.
- out_word_cnt increments on out_acc and wraps 0xFFFFFFFF -> 0.
- The input stalls only while out_pvld=1 and out_prdy=0; no beat is lost or duplicated.

Decomposition:
- Shared package (sdp_y_pack_pkg):
  - IW/RATIO defaults;
  - mask-generation function (cnt -> thermometer mask);
  - typedef for the segment counter.
- Natural sub-module: nv_nvdla_sdp_y_pack_ctrl, holding pack_cnt, ratio latch, is_last, out_pvld/mask/last and out_word_cnt.
- The segment register array and output gating stay in the top.

Test Plan:
- Full group: cfg_ratio_m1=3, four beats 0xA..0xD, out_prdy=1 -> one cycle after beat 4:
  - out_pvld=1, out_mask=4'b1111, out_last=0;
  - out_data segments 3..0 = D,C,B,A;
  - out_word_cnt=1 after accept.
- Early close: cfg_ratio_m1=3, beats 0x11, 0x22 with inp_last on the second ->
  - out_mask=4'b0011, out_last=1;
  - segments 3,2 = 0, segment 1 = 0x22, segment 0 = 0x11;
  - next group starts at segment 0.
- Backpressure: complete a group with out_prdy=0 for 5 cycles ->
  - inp_prdy=0 throughout and outputs stable;
  - on the out_prdy=1 cycle, a new beat is accepted into segment 0 in the same cycle.
- Pass-through: cfg_ratio_m1=0, 8 consecutive beats, out_prdy=1 ->
  - 8 words on 8 consecutive cycles;
  - each out_mask=4'b0001, segment 0 = input.
- Mid-group cfg change: start with cfg_ratio_m1=1, change to 3 after beat 1 -> group closes after 2 beats with mask 4'b0011; the next group uses 4 beats.
- Reset mid-group: 2 beats accepted, then nvdla_core_rst high for 1 cycle -> out_pvld stays 0; the next 4 beats produce exactly one word with mask 4'b1111.
